pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 122 ++++++++++++
 tb/tb_pc_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program counter generator with BOOT/RUN/HALT control.
// Reset is synchronous and active-high. After reset the block spends one BOOT
// cycle at RESET_VECTOR and then fetches sequentially in RUN. Traps, redirects,
// stalls and halt requests override the sequential advance in that priority.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   stall, half_inc                hold PC / current instruction is 2 bytes
//   redirect_valid/redirect_target branch or jump redirect
//   trap_valid/trap_vector         trap entry, alignment not checked
//   halt_req, resume               halt control
//   pc, pc_next_seq                fetch address / combinational sequential successor
//   pc_valid, misalign_err, halted registered status
module pc_gen #(
  parameter int unsigned      XLEN         = 64,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      INC          = 4,
  parameter bit               COMPRESSED   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            half_inc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic            halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] step;
  logic            misaligned;

  // Sequential increment; half_inc only matters in compressed builds.
  always_comb begin
    step = XLEN'(INC);
    if (COMPRESSED && half_inc) step = XLEN'(2);
  end

  // Natural XLEN-bit wrap gives the modulo 2^XLEN arithmetic.
  assign pc_next_seq = pc + step;

  // Redirect alignment: 2-byte granule when compressed, 4-byte otherwise.
  always_comb begin
    if (COMPRESSED) misaligned = redirect_target[0];
    else            misaligned = (redirect_target[1:0] != 2'b00);
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_VECTOR;
      pc_valid     <= 1'b0;
      misalign_err <= 1'b0;
      halted       <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        // One cycle at RESET_VECTOR with every request ignored.
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (trap_valid) begin
            pc <= trap_vector;
          end else if (redirect_valid) begin
            if (misaligned) begin
              // Reject: keep pc, flag for one cycle, park in HALT.
              state        <= HALT;
              pc_valid     <= 1'b0;
              halted       <= 1'b1;
              misalign_err <= 1'b1;
            end else begin
              pc <= redirect_target;
            end
          end else if (stall) begin
            pc <= pc;
          end else if (halt_req) begin
            state    <= HALT;
            pc_valid <= 1'b0;
            halted   <= 1'b1;
          end else begin
            pc <= pc_next_seq;
          end
        end
        HALT: begin
          if (trap_valid) begin
            pc       <= trap_vector;
            state    <= RUN;
            pc_valid <= 1'b1;
            halted   <= 1'b0;
          end else if (resume) begin
            state    <= RUN;
            pc_valid <= 1'b1;
            halted   <= 1'b0;
          end
        end
        default: begin
          state    <= BOOT;
          pc       <= RESET_VECTOR;
          pc_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: two instances (4-byte only, and compressed with a
// non-zero reset vector) share one stimulus stream and are checked every
// cycle against a priority-ordered behavioural model, plus literal checks.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, half_inc, redirect_valid, trap_valid, halt_req, resume;
  logic [63:0] redirect_target, trap_vector;

  logic [63:0] pc_a[2];
  logic [63:0] nseq_a[2];
  logic        valid_a[2];
  logic        err_a[2];
  logic        halt_a[2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(64), .RESET_VECTOR(64'h0), .INC(4), .COMPRESSED(1'b0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .half_inc(half_inc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .halt_req(halt_req), .resume(resume),
    .pc(pc_a[0]), .pc_next_seq(nseq_a[0]), .pc_valid(valid_a[0]),
    .misalign_err(err_a[0]), .halted(halt_a[0])
  );

  pc_gen #(.XLEN(64), .RESET_VECTOR(64'h10), .INC(4), .COMPRESSED(1'b1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .half_inc(half_inc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .halt_req(halt_req), .resume(resume),
    .pc(pc_a[1]), .pc_next_seq(nseq_a[1]), .pc_valid(valid_a[1]),
    .misalign_err(err_a[1]), .halted(halt_a[1])
  );

  // ---------------- model ----------------
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  bit          comp[2] = '{1'b0, 1'b1};
  logic [63:0] rvec[2] = '{64'h0, 64'h10};

  int          m_mode[2];
  logic [63:0] m_pc[2];
  bit          m_err[2];
  bit          m_live = 1'b0;

  function automatic logic [63:0] seq_step(input int i, input logic h);
    return (comp[i] && h) ? 64'd2 : 64'd4;
  endfunction

  function automatic bit aligned(input int i, input logic [63:0] t);
    return (t % (comp[i] ? 64'd2 : 64'd4)) == 64'd0;
  endfunction

  task automatic model_step(input int i);
    m_err[i] = 1'b0;
    if (rst) begin
      m_mode[i] = M_BOOT;
      m_pc[i]   = rvec[i];
    end else if (m_mode[i] == M_BOOT) begin
      m_mode[i] = M_RUN;
    end else if (trap_valid) begin
      m_pc[i]   = trap_vector;
      m_mode[i] = M_RUN;
    end else if (m_mode[i] == M_HALT) begin
      if (resume) m_mode[i] = M_RUN;
    end else if (redirect_valid) begin
      if (aligned(i, redirect_target)) m_pc[i] = redirect_target;
      else begin
        m_err[i]  = 1'b1;
        m_mode[i] = M_HALT;
      end
    end else if (stall) begin
      m_pc[i] = m_pc[i];
    end else if (halt_req) begin
      m_mode[i] = M_HALT;
    end else begin
      m_pc[i] = m_pc[i] + seq_step(i, half_inc);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    if (rst) m_live = 1'b1;
    #1;
    if (m_live) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("pc[%0d]", i), pc_a[i], m_pc[i]);
        chk($sformatf("pc_next_seq[%0d]", i), nseq_a[i], m_pc[i] + seq_step(i, half_inc));
        chk($sformatf("pc_valid[%0d]", i), 64'(valid_a[i]), 64'(m_mode[i] == M_RUN));
        chk($sformatf("halted[%0d]", i), 64'(halt_a[i]), 64'(m_mode[i] == M_HALT));
        chk($sformatf("misalign_err[%0d]", i), 64'(err_a[i]), 64'(m_err[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
    halt_req = 1'b0; resume = 1'b0;
  endtask

  // Inputs change 2 time units after the edge, clear of the model/compare slot.
  task automatic go();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clr();
    half_inc = 1'b0; redirect_target = '0; trap_vector = '0;
    rst = 1'b1;
    go();
    chk("boot_pc", pc_a[0], 64'h0);
    chk("boot_valid", 64'(valid_a[0]), 64'h0);
    chk("boot_halted", 64'(halt_a[0]), 64'h0);
    chk("boot_err", 64'(err_a[0]), 64'h0);
    chk("boot_pc_c", pc_a[1], 64'h10);
    rst = 1'b0;
    go();
    chk("run0_pc", pc_a[0], 64'h0);
    chk("run0_valid", 64'(valid_a[0]), 64'h1);
    half_inc = 1'b1; go();
    chk("seq_pc4", pc_a[0], 64'h4);
    chk("half_pc12", pc_a[1], 64'h12);
    half_inc = 1'b0; go();
    chk("seq_pc8", pc_a[0], 64'h8);
    chk("half_pc16", pc_a[1], 64'h16);
    go();
    chk("seq_pc12", pc_a[0], 64'hC);
    chk("seq_next16", nseq_a[0], 64'h10);

    // Priority: trap beats redirect beats stall.
    redirect_valid = 1'b1; redirect_target = 64'h40; go(); clr();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 64'h200;
    trap_valid = 1'b1; trap_vector = 64'h80; go(); clr();
    chk("prio_trap", pc_a[0], 64'h80);
    redirect_valid = 1'b1; redirect_target = 64'h40; go(); clr();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 64'h200; go(); clr();
    chk("prio_redirect", pc_a[0], 64'h200);

    // Stall holds with pc_valid high.
    stall = 1'b1; go(); go(); clr();
    chk("stall_pc", pc_a[0], 64'h200);
    chk("stall_valid", 64'(valid_a[0]), 64'h1);

    // Halt, ignored requests in HALT, resume.
    halt_req = 1'b1; go(); clr();
    chk("halt_flag", 64'(halt_a[0]), 64'h1);
    chk("halt_valid", 64'(valid_a[0]), 64'h0);
    redirect_valid = 1'b1; redirect_target = 64'h300; stall = 1'b1; halt_req = 1'b1; go(); clr();
    chk("halt_ignore_pc", pc_a[0], 64'h200);
    resume = 1'b1; go(); clr();
    chk("resume_pc", pc_a[0], 64'h200);
    chk("resume_valid", 64'(valid_a[0]), 64'h1);
    go();
    chk("resume_seq", pc_a[0], 64'h204);

    // Misaligned redirect on the 4-byte instance only.
    redirect_valid = 1'b1; redirect_target = 64'h102; go(); clr();
    chk("mis_pc", pc_a[0], 64'h204);
    chk("mis_err", 64'(err_a[0]), 64'h1);
    chk("mis_halted", 64'(halt_a[0]), 64'h1);
    chk("c_aligned_pc", pc_a[1], 64'h102);
    go();
    chk("mis_err_pulse", 64'(err_a[0]), 64'h0);
    resume = 1'b1; go(); clr();
    chk("mis_resume_pc", pc_a[0], 64'h204);
    chk("mis_resume_valid", 64'(valid_a[0]), 64'h1);

    // Odd target misaligned on both; trap in HALT wins over resume.
    redirect_valid = 1'b1; redirect_target = 64'h101; go(); clr();
    chk("c_mis_err", 64'(err_a[1]), 64'h1);
    trap_valid = 1'b1; trap_vector = 64'h400; resume = 1'b1; go(); clr();
    chk("halt_trap_pc", pc_a[0], 64'h400);
    chk("halt_trap_pc_c", pc_a[1], 64'h400);

    // Wrap-around.
    redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC; go(); clr();
    chk("wrap_top", pc_a[0], 64'hFFFF_FFFF_FFFF_FFFC);
    go();
    chk("wrap_zero", pc_a[0], 64'h0);
    chk("wrap_err", 64'(err_a[0]), 64'h0);

    // Reset from HALT and mid-stall.
    halt_req = 1'b1; go(); clr();
    rst = 1'b1; go(); clr();
    chk("rst_halt_halted", 64'(halt_a[0]), 64'h0);
    chk("rst_halt_pc_c", pc_a[1], 64'h10);
    go();
    stall = 1'b1; go();
    rst = 1'b1; go();
    chk("rst_stall_valid", 64'(valid_a[0]), 64'h0);
    chk("rst_stall_pc_c", pc_a[1], 64'h10);
    rst = 1'b0; go(); clr();
    chk("rst_stall_run", 64'(valid_a[1]), 64'h1);

    // BOOT ignores everything but rst.
    rst = 1'b1; go(); clr();
    trap_valid = 1'b1; trap_vector = 64'h500; redirect_valid = 1'b1;
    redirect_target = 64'h600; halt_req = 1'b1; go(); clr();
    chk("boot_ignore_pc", pc_a[0], 64'h0);
    chk("boot_ignore_valid", 64'(valid_a[0]), 64'h1);

    // Trap ignores alignment.
    trap_valid = 1'b1; trap_vector = 64'h403; go(); clr();
    chk("trap_odd_pc", pc_a[0], 64'h403);
    chk("trap_odd_err", 64'(err_a[0]), 64'h0);
    go();
    chk("trap_odd_seq", pc_a[0], 64'h407);

    go();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
